mbist_march_ctrl: RTL

- March C- memory BIST controller; the initiator that drives `fault_mem`-style single-port memories through their `write_read`/`address`/`wdata`/`rdata` port.
- Runs the six-element March C- sequence at one memory operation per clock.
- Compares every read against the expected data background and reports pass/fail, first failing address/element and a failure count.
- Sits between the top-level test sequencer (start/done) and the memory under test.

---
 rtl/mbist_march_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- BIST controller for a single-port memory with registered wdata and 2-cycle reads.
// Ports: clk/rst (async, active-high); start/busy/done handshake with the test sequencer;
// fail/fail_addr/fail_element/fail_count report the run; write_read/address/wdata/rdata drive the memory.
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_element,
    output logic [7:0]            fail_count,
    output logic                  write_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata
);
    localparam logic [2:0] IDLE = 3'd0, PRE = 3'd1, RUN = 3'd2, DRAIN = 3'd3, DONE = 3'd4;
    localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(CAPACITY);
    logic [2:0] state, el, cur_el, n_el;
    logic [ADDR_WIDTH-1:0] ad, n_ad;
    logic ph, n_ph, last, op_vld, drn, dn, end_a, split, fin;
    logic s0_vld, s0_b, s1_vld, s1_b;
    logic [ADDR_WIDTH-1:0] s0_ad, s1_ad;
    logic [2:0] s0_el, s1_el;
    function automatic logic is_wr(input logic [2:0] e, input logic p);
        return e == 3'd0 || (e != 3'd5 && p);
    endfunction
    function automatic logic [DATA_WIDTH-1:0] bg(input logic b);
        return b ? '1 : '0;
    endfunction
    // (el, ad, ph) is the op issued on the next edge; n_* is the one after it, which wdata must lead
    always_comb begin
        dn    = el == 3'd3 || el == 3'd4;
        end_a = dn ? ad == '0 : ad == TOP;
        split = el != 3'd0 && el != 3'd5;
        fin   = el == 3'd5 && ad == TOP;
        n_el  = el;
        n_ad  = ad;
        n_ph  = 1'b0;
        if (split && !ph)
            n_ph = 1'b1;
        else if (end_a) begin
            n_el = el + 3'd1;
            n_ad = (el == 3'd2 || el == 3'd3) ? TOP : '0;
        end else
            n_ad = dn ? ad - 1'b1 : ad + 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            {busy, done, fail, fail_addr, fail_element, fail_count} <= '0;
            {write_read, address, wdata} <= '0;
            {el, ad, ph, cur_el, last, op_vld, drn} <= '0;
            {s0_vld, s0_b, s0_ad, s0_el, s1_vld, s1_b, s1_ad, s1_el} <= '0;
        end else begin
            // read pipeline: expected background is all-ones for reads in even elements
            s0_vld <= op_vld && !write_read;
            s0_b   <= ~cur_el[0];
            s0_ad  <= address;
            s0_el  <= cur_el;
            {s1_vld, s1_b, s1_ad, s1_el} <= {s0_vld, s0_b, s0_ad, s0_el};
            if (s1_vld && rdata != bg(s1_b)) begin
                fail <= 1'b1;
                if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
                if (!fail) {fail_addr, fail_element} <= {s1_ad, s1_el};
            end
            if (state == PRE || (state == RUN && !last)) begin
                state      <= RUN;
                write_read <= is_wr(el, ph);
                address    <= ad;
                cur_el     <= el;
                op_vld     <= 1'b1;
                last       <= fin;
                {el, ad, ph} <= {n_el, n_ad, n_ph};
                if (is_wr(n_el, n_ph)) wdata <= bg(n_el[0]);
            end else if (state == RUN) begin
                state      <= DRAIN;
                write_read <= 1'b0;
                address    <= '0;
                op_vld     <= 1'b0;
                drn        <= 1'b0;
            end else if (state == DRAIN) begin
                drn <= 1'b1;
                if (drn) {state, busy, done} <= {DONE, 1'b0, 1'b1};
            end else if (start) begin
                // accepted start; later assignments here override any compare result on this edge
                state <= PRE;
                {busy, done} <= 2'b10;
                {fail, fail_addr, fail_element, fail_count} <= '0;
                {el, ad, ph, last} <= '0;
                wdata <= '0;
            end
        end
    end
endmodule
